// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - step sequencer: a pattern of pitch codes played at a programmable tempo with a gate envelope
module melody_sequencer #(
    parameter int TEMPO_WIDTH = 24,
    parameter int DEPTH       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [TEMPO_WIDTH-1:0] tempo_div,
    input  logic [TEMPO_WIDTH-1:0] gate_len,
    input  logic [3:0]             last_step,
    input  logic                   wr_en,
    input  logic [3:0]             wr_addr,
    input  logic [3:0]             wr_pitch,
    output logic [3:0]             pitch,
    output logic                   gate,
    output logic [3:0]             step,
    output logic                   step_pulse
);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t                 state_q, state_d;
    logic [TEMPO_WIDTH-1:0] tick_q, tick_d, tick_last;
    logic [3:0]             step_d, pitch_d, nxt;
    logic                   gate_d, pulse_d;
    logic [3:0]             mem [DEPTH];

    // Reads are combinational from the current array, so a write on the same edge is not seen.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_addr] <= wr_pitch;
        end
    end

    // tempo_div of 0 and 1 both collapse to a single-clock step.
    assign tick_last = (tempo_div > TEMPO_WIDTH'(1)) ? tempo_div - TEMPO_WIDTH'(1) : '0;
    assign nxt       = (step >= last_step) ? 4'd0 : step + 4'd1;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        step_d  = step;
        pitch_d = pitch;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                tick_d  = '0;
                step_d  = 4'd0;
                pitch_d = 4'd0;
                if (run) begin
                    state_d = PLAY;
                    pitch_d = mem[4'd0];
                    pulse_d = 1'b1;
                end
            end
            PLAY: begin
                if (!run) begin
                    state_d = IDLE;
                    tick_d  = '0;
                    step_d  = 4'd0;
                    pitch_d = 4'd0;
                end else if (tick_q >= tick_last) begin
                    // >= rather than == so a tempo lowered mid-step still advances at once.
                    tick_d  = '0;
                    step_d  = nxt;
                    pitch_d = mem[nxt];
                    pulse_d = 1'b1;
                end else begin
                    tick_d = tick_q + TEMPO_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        gate_d = (state_d == PLAY) && (pitch_d != 4'd0) && (tick_d < gate_len);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            step       <= 4'd0;
            pitch      <= 4'd0;
            gate       <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            step       <= step_d;
            pitch      <= pitch_d;
            gate       <= gate_d;
            step_pulse <= pulse_d;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - directed and randomized checks of melody_sequencer against a behavioural model
module tb_melody_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [23:0] tempo_div = 24'd4;
    logic [23:0] gate_len = 24'd2;
    logic [3:0]  last_step = 4'd3;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [3:0]  wr_pitch = 4'd0;
    logic [3:0]  pitch;
    logic        gate;
    logic [3:0]  step;
    logic        step_pulse;

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural model: position within the melody in terms of whole steps and clocks elapsed.
    bit m_play = 0;
    int m_step = 0;
    int m_elapsed = 0;
    int m_pitch = 0;
    bit m_gate = 0;
    bit m_pulse = 0;
    int m_mem [16];

    melody_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .tempo_div(tempo_div), .gate_len(gate_len),
        .last_step(last_step), .wr_en(wr_en), .wr_addr(wr_addr), .wr_pitch(wr_pitch),
        .pitch(pitch), .gate(gate), .step(step), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int steps_per_tempo;
        steps_per_tempo = (tempo_div < 2) ? 1 : int'(tempo_div);
        m_pulse = 0;
        if (rst) begin
            m_play = 0;
            m_step = 0;
            m_elapsed = 0;
            m_pitch = 0;
        end else if (!m_play || !run) begin
            m_step = 0;
            m_elapsed = 0;
            m_pitch = 0;
            if (!m_play && run) begin
                m_play = 1;
                m_pitch = m_mem[0];
                m_pulse = 1;
            end else begin
                m_play = 0;
            end
        end else if (m_elapsed + 1 >= steps_per_tempo) begin
            m_step = (m_step >= int'(last_step)) ? 0 : m_step + 1;
            m_elapsed = 0;
            m_pitch = m_mem[m_step];
            m_pulse = 1;
        end else begin
            m_elapsed++;
        end
        m_gate = m_play && (m_pitch != 0) && (m_elapsed < int'(gate_len));
        if (!rst && wr_en) m_mem[wr_addr] = int'(wr_pitch);
    endtask

    task automatic clk_step();
        model_update();
        @(posedge clk);
        #1;
        chk("pitch", 32'(pitch), 32'(m_pitch));
        chk("gate", 32'(gate), 32'(m_gate));
        chk("step", 32'(step), 32'(m_step));
        chk("step_pulse", 32'(step_pulse), 32'(m_pulse));
        @(negedge clk);
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1;
        wr_addr = 4'(a);
        wr_pitch = 4'(d);
        clk_step();
        wr_en = 1'b0;
    endtask

    task automatic run_until(input string tag, input int s, input int e);
        bit found;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (m_play && m_step == s && m_elapsed == e) found = 1;
            else clk_step();
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        @(negedge clk);
        clk_step();
        clk_step();
        chk("reset_pitch", 32'(pitch), 32'd0);
        chk("reset_pulse", 32'(step_pulse), 32'd0);
        rst = 1'b0;

        // Basic four-step pattern with a rest on step 2.
        wr(0, 1); wr(1, 5); wr(2, 0); wr(3, 8);
        tempo_div = 24'd4; gate_len = 24'd2; last_step = 4'd3;
        run = 1'b1;
        clk_step();
        chk("first_pitch", 32'(pitch), 32'd1);
        chk("first_pulse", 32'(step_pulse), 32'd1);
        for (int i = 0; i < 19; i++) clk_step();
        chk("wrap_pitch", 32'(pitch), 32'd1);
        run = 1'b0;
        clk_step();

        // Single-clock steps alternate between two entries.
        tempo_div = 24'd0; last_step = 4'd1;
        wr(0, 3); wr(1, 7);
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            clk_step();
            chk("alt_pitch", 32'(pitch), (i % 2 == 1) ? 32'd7 : 32'd3);
            chk("alt_pulse", 32'(step_pulse), 32'd1);
        end
        run = 1'b0;
        clk_step();

        // Legato: gate longer than the step.
        wr(0, 5); wr(1, 6);
        tempo_div = 24'd4; gate_len = 24'd10;
        run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            clk_step();
            chk("legato_gate", 32'(gate), 32'd1);
        end
        run = 1'b0;
        clk_step();

        // Writes to the playing step and to the next one.
        wr(0, 2); wr(1, 4); wr(2, 6); wr(3, 1);
        tempo_div = 24'd8; gate_len = 24'd3; last_step = 4'd3;
        run = 1'b1;
        run_until("reach_step2", 2, 1);
        wr(2, 9);
        wr(3, 9);
        for (int i = 0; i < 4; i++) begin
            clk_step();
            chk("hold_pitch", 32'(pitch), 32'd6);
        end
        run_until("reach_step3", 3, 0);
        chk("step3_pitch", 32'(pitch), 32'd9);
        run = 1'b0;
        clk_step();

        // Lowering last_step below the current step wraps to 0.
        for (int a = 4; a < 16; a++) wr(a, a);
        tempo_div = 24'd2; last_step = 4'd7;
        run = 1'b1;
        run_until("reach_step6", 6, 0);
        last_step = 4'd3;
        clk_step();
        clk_step();
        chk("shrink_wrap", 32'(step), 32'd0);

        // Stop mid-step, then restart from step 0.
        tempo_div = 24'd4;
        run_until("reach_tick2", 1, 2);
        run = 1'b0;
        clk_step();
        chk("stop_pitch", 32'(pitch), 32'd0);
        chk("stop_gate", 32'(gate), 32'd0);
        run = 1'b1;
        clk_step();
        chk("restart_step", 32'(step), 32'd0);

        // Reset while playing and writing.
        for (int i = 0; i < 3; i++) clk_step();
        rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_pitch = 4'd15;
        clk_step();
        chk("rst_pitch", 32'(pitch), 32'd0);
        chk("rst_gate", 32'(gate), 32'd0);
        wr_en = 1'b0;
        clk_step();
        rst = 1'b0; run = 1'b0;
        clk_step();
        clk_step();
        chk("rst_idle", 32'(step_pulse), 32'd0);
        run = 1'b1;
        clk_step();
        chk("rst_mem_kept", 32'(pitch), 32'd2);

        // Randomized playback with live parameter changes, writes and occasional reset.
        for (int i = 0; i < 16; i++) wr(i, int'($urandom_range(0, 15)));
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) run = ~run;
            rst = ($urandom_range(0, 199) == 0);
            wr_en = ($urandom_range(0, 3) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_pitch = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) begin
                tempo_div = 24'($urandom_range(0, 5));
                gate_len = 24'($urandom_range(0, 6));
                last_step = 4'($urandom_range(0, 15));
            end
            clk_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
